// File: rtl/dout_mismatch_scoreboard.sv
// Reference-vs-DUT compare scoreboard: saturating sample/error counters plus first-failure capture.
// Define MISMATCH_FIRST_CAPTURE_EN to build the first_err_at/first_err_bits capture registers.
module dout_mismatch_scoreboard #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] ref_vec,
  input  logic [WIDTH-1:0] dut_vec,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] errors,
  output logic [CNT_W-1:0] first_err_at,
  output logic [WIDTH-1:0] first_err_bits,
  output logic             err_flag,
  output logic             sat
);

  // sample_en is a plain valid: every asserted cycle is consumed, there is no ready/backpressure.
  typedef enum logic {CLEAN = 1'b0, FAILED = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] diff;
  logic             mismatch;

  assign diff     = ref_vec ^ dut_vec;
  assign mismatch = sample_en && (diff != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = CLEAN;
    end else if (state == CLEAN && mismatch) begin
      state_nxt = FAILED;
    end
  end

  assign err_flag = (state == FAILED);

  // Counters hold at all-ones; errors never outruns samples because it only moves on a sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samples <= '0;
      errors  <= '0;
    end else if (clear) begin
      samples <= '0;
      errors  <= '0;
    end else begin
      if (sample_en && samples != CNT_MAX) begin
        samples <= samples + 1'b1;
      end
      if (mismatch && errors != CNT_MAX) begin
        errors <= errors + 1'b1;
      end
    end
  end

  assign sat = (samples == CNT_MAX);

`ifdef MISMATCH_FIRST_CAPTURE_EN
  logic first_hit;

  assign first_hit = (state == CLEAN) && mismatch && !clear;

  // samples here is the pre-increment value, i.e. the 0-based index of this sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_at   <= '0;
      first_err_bits <= '0;
    end else if (clear) begin
      first_err_at   <= '0;
      first_err_bits <= '0;
    end else if (first_hit) begin
      first_err_at   <= samples;
      first_err_bits <= diff;
    end
  end
`else
  assign first_err_at   = '0;
  assign first_err_bits = '0;
`endif

endmodule
